// File: rtl/plus_one_adder.sv
// Registered signed incrementer (out = in + 1) built from 4-bit lookahead groups.
// Flags signed overflow when the operand is MAX_INT; optional saturation.
module plus_one_adder #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int GROUPS = WIDTH / 4;

    logic [GROUPS-1:0] cin;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  result;
    logic              max_hit;

    assign cin[0] = 1'b1;

    // Adding a constant 1 means generate is always 0: carries are pure ANDs.
    for (genvar g = 0; g < GROUPS; g++) begin : grp
        for (genvar k = 0; k < 4; k++) begin : bitk
            if (k == 0) begin : lsb
                assign carry[4*g] = cin[g];
            end else begin : upper
                assign carry[4*g+k] = cin[g] & (&in[4*g+k-1:4*g]);
            end
            assign sum[4*g+k] = in[4*g+k] ^ carry[4*g+k];
        end

        if (g < GROUPS - 1) begin : nxt
            logic gp;
            assign gp       = &in[4*g+3:4*g];
            assign cin[g+1] = cin[g] & gp;
        end
    end

    // Carry into a clear MSB only happens for MAX_INT.
    assign max_hit = carry[WIDTH-1] & ~in[WIDTH-1];

    always_comb begin
        result = sum;
        if (SATURATE && max_hit) begin
            result = in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out      <= result;
                overflow <= max_hit;
            end
        end
    end

endmodule

// File: tb/tb_plus_one_adder.sv
// Directed bench for plus_one_adder: wrapping and saturating builds side by side.
module tb_plus_one_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid, overflow;
    logic [15:0] out_data;
    logic        sat_valid, sat_ovf;
    logic [15:0] sat_out;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    plus_one_adder #(.WIDTH(16), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_data),
        .out_valid(out_valid), .out(out_data), .overflow(overflow)
    );

    plus_one_adder #(.WIDTH(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_data),
        .out_valid(sat_valid), .out(sat_out), .overflow(sat_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd5;
        tick();
        tick();
        compared += 3;
        if (out_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_out: got %h want 0000", out_data);
        end
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        if (overflow !== 1'b0 || sat_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ovf: got %b/%b want 0/0", overflow, sat_ovf);
        end
        rst_n = 1'b1;
        tick();
        compared += 3;
        if (out_data !== 16'h0006) begin
            mismatched++;
            $display("FAIL release_out: got %h want 0006", out_data);
        end
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL release_valid: got %b want 1", out_valid);
        end
        if (sat_out !== 16'h0006) begin
            mismatched++;
            $display("FAIL release_sat_out: got %h want 0006", sat_out);
        end
    endtask

    task automatic test_max_operand();
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        tick();
        compared += 4;
        if (out_data !== 16'h8000) begin
            mismatched++;
            $display("FAIL max_wrap_out: got %h want 8000", out_data);
        end
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL max_wrap_ovf: got %b want 1", overflow);
        end
        if (sat_out !== 16'h7FFF) begin
            mismatched++;
            $display("FAIL max_sat_out: got %h want 7fff", sat_out);
        end
        if (sat_ovf !== 1'b1) begin
            mismatched++;
            $display("FAIL max_sat_ovf: got %b want 1", sat_ovf);
        end
    endtask

    task automatic test_carry_chain();
        logic [15:0] ops [4] = '{16'hFFFF, 16'h00FF, 16'h0FFF, 16'h000F};
        logic [15:0] exps[4] = '{16'h0000, 16'h0100, 16'h1000, 16'h0010};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
            compared += 3;
            if (out_data !== exps[i] || sat_out !== exps[i]) begin
                mismatched++;
                $display("FAIL carry_%0d: got %h/%h want %h",
                         i, out_data, sat_out, exps[i]);
            end
            if (overflow !== 1'b0 || sat_ovf !== 1'b0) begin
                mismatched++;
                $display("FAIL carry_ovf_%0d: got %b/%b want 0",
                         i, overflow, sat_ovf);
            end
            if (out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL carry_valid_%0d: got %b want 1", i, out_valid);
            end
        end
    endtask

    task automatic test_negative_boundary();
        in_valid = 1'b1;
        in_data  = 16'h8000;
        tick();
        compared += 2;
        if (out_data !== 16'h8001 || sat_out !== 16'h8001) begin
            mismatched++;
            $display("FAIL min_int_out: got %h/%h want 8001",
                     out_data, sat_out);
        end
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL min_int_ovf: got %b want 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops[9];
        logic [15:0] exp_wrap, exp_sat;
        logic        exp_ovf;
        for (int i = 0; i < 9; i++) ops[i] = 16'($random);
        ops[4] = 16'h7FFF;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
            exp_ovf  = (ops[i] == 16'h7FFF);
            exp_wrap = 16'((32'(ops[i]) + 32'd1) & 32'hFFFF);
            exp_sat  = exp_ovf ? 16'h7FFF : exp_wrap;
            compared += 4;
            if (out_data !== exp_wrap) begin
                mismatched++;
                $display("FAIL b2b_out_%0d: in %h got %h want %h",
                         i, ops[i], out_data, exp_wrap);
            end
            if (sat_out !== exp_sat) begin
                mismatched++;
                $display("FAIL b2b_sat_%0d: in %h got %h want %h",
                         i, ops[i], sat_out, exp_sat);
            end
            if (overflow !== exp_ovf || sat_ovf !== exp_ovf) begin
                mismatched++;
                $display("FAIL b2b_ovf_%0d: got %b/%b want %b",
                         i, overflow, sat_ovf, exp_ovf);
            end
            if (out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_valid_%0d: got %b want 1", i, out_valid);
            end
        end
    endtask

    task automatic test_bubble_and_reset();
        in_valid = 1'b1;
        in_data  = 16'd100;
        tick();
        compared++;
        if (out_data !== 16'd101) begin
            mismatched++;
            $display("FAIL bubble_load: got %0d want 101", out_data);
        end
        in_valid = 1'b0;
        in_data  = 16'h1234;
        tick();
        compared += 3;
        if (out_data !== 16'd101) begin
            mismatched++;
            $display("FAIL bubble_hold: got %0d want 101", out_data);
        end
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bubble_valid: got %b want 0", out_valid);
        end
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL bubble_ovf: got %b want 0", overflow);
        end
        in_data = 'x;
        tick();
        compared++;
        if (out_data !== 16'd101 || sat_out !== 16'd101) begin
            mismatched++;
            $display("FAIL x_hold: got %h/%h want 0065", out_data, sat_out);
        end
        in_valid = 1'b1;
        in_data  = 16'd50;
        tick();
        compared++;
        if (out_data !== 16'd51 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset: got %0d/%b want 51/1",
                     out_data, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared += 2;
        if (out_data !== 16'h0000 || sat_out !== 16'h0000) begin
            mismatched++;
            $display("FAIL async_reset_out: got %h/%h want 0000",
                     out_data, sat_out);
        end
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_valid: got %b want 0", out_valid);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL post_release_idle: got %b/%h want 0/0000",
                     out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_max_operand();
        test_carry_chain();
        test_negative_boundary();
        test_back_to_back();
        test_bubble_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
